// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU writeback path.
//   FREG_ADDR_W : float register index width
//   FDATA_W     : float result word width
//   fwb_entry_t : one buffered result, {address, data}
package fpu_pkg;

  localparam int FREG_ADDR_W = 5;
  localparam int FDATA_W     = 32;

  typedef struct packed {
    logic [FREG_ADDR_W-1:0] address;
    logic [FDATA_W-1:0]     data;
  } fwb_entry_t;

endpackage

// File: rtl/fpu_wb_fifo.sv
// Single-source result FIFO for the FPU writeback collector.
// Ports:
//   clk, rstn      : clock, asynchronous active-low reset
//   i_push/i_entry : write request and the entry to store
//   i_pop          : remove the head entry (ignored when empty)
//   o_head         : current head entry
//   o_full/o_empty : occupancy flags
//   o_count        : current occupancy
//   o_count_next   : occupancy after this edge's push/pop
module fpu_wb_fifo
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  fwb_entry_t               i_entry,
  input  logic                     i_pop,
  output fwb_entry_t               o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [$clog2(DEPTH):0]   o_count_next
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fwb_entry_t      r_mem [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;
  logic            w_pop;
  logic            w_wr;
  logic [CW-1:0]   w_count_next;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop && !o_empty;
  // A full FIFO still accepts a push when its head leaves in the same cycle.
  assign w_wr    = i_push && (!o_full || w_pop);

  always_comb begin
    w_count_next = r_count;
    if (w_wr && !w_pop) begin
      w_count_next = r_count + 1'b1;
    end else if (!w_wr && w_pop) begin
      w_count_next = r_count - 1'b1;
    end
  end

  // Storage has no reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_entry;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_count <= w_count_next;
    end
  end

  // Head is read asynchronously so the arbiter's grant and data line up in
  // one cycle; at this depth the array maps to distributed memory.
  assign o_head       = r_mem[r_rptr];
  assign o_count      = r_count;
  assign o_count_next = w_count_next;

endmodule

// File: rtl/fpu_writeback.sv
// Writeback collector: buffers tagged results from N_SRC FPU pipelines and
// serialises them onto one register-file write port, round-robin.
// Ports:
//   clk, rstn     : clock, asynchronous active-low reset
//   src_flag      : per-source result valid
//   src_address   : per-source destination register, source i at [5i+4:5i]
//   src_data      : per-source result, source i at [32i+31:32i]
//   wr_flag/wr_address/wr_data : registered register-file write port
//   stall_req     : registered throttle request to issue
//   busy          : any FIFO non-empty
//   overflow_err  : sticky per-source dropped-result indication
module fpu_writeback
  import fpu_pkg::*;
#(
  parameter int N_SRC    = 4,
  parameter int DEPTH    = 4,
  parameter int STALL_TH = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic [N_SRC-1:0]             src_flag,
  input  logic [FREG_ADDR_W*N_SRC-1:0] src_address,
  input  logic [FDATA_W*N_SRC-1:0]     src_data,
  output logic                         wr_flag,
  output logic [FREG_ADDR_W-1:0]       wr_address,
  output logic [FDATA_W-1:0]           wr_data,
  output logic                         stall_req,
  output logic                         busy,
  output logic [N_SRC-1:0]             overflow_err
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int RRW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  fwb_entry_t        w_in    [N_SRC];
  fwb_entry_t        w_head  [N_SRC];
  logic [CW-1:0]     w_count [N_SRC];
  logic [CW-1:0]     w_count_next [N_SRC];
  logic [N_SRC-1:0]  w_full;
  logic [N_SRC-1:0]  w_empty;
  logic [N_SRC-1:0]  w_grant_vec;
  logic [N_SRC-1:0]  w_drop;
  logic              w_grant_vld;
  logic [RRW-1:0]    w_grant_idx;
  logic [RRW:0]      w_cand;
  logic [RRW-1:0]    w_rr_next;
  fwb_entry_t        w_head_sel;
  logic              w_stall_next;
  logic              w_busy;

  logic [RRW-1:0]    r_rr;
  logic              r_wr_flag;
  fwb_entry_t        r_wr_entry;
  logic              r_stall;
  logic [N_SRC-1:0]  r_ovf;

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
    assign w_in[gi] = {src_address[FREG_ADDR_W*gi +: FREG_ADDR_W],
                       src_data[FDATA_W*gi +: FDATA_W]};

    fpu_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .rstn         (rstn),
      .i_push       (src_flag[gi]),
      .i_entry      (w_in[gi]),
      .i_pop        (w_grant_vec[gi]),
      .o_head       (w_head[gi]),
      .o_full       (w_full[gi]),
      .o_empty      (w_empty[gi]),
      .o_count      (w_count[gi]),
      .o_count_next (w_count_next[gi])
    );
  end

  // First non-empty FIFO at or above rr, wrapping modulo N_SRC.
  always_comb begin
    w_grant_vld = 1'b0;
    w_grant_idx = '0;
    w_grant_vec = '0;
    w_cand      = '0;
    for (int k = 0; k < N_SRC; k++) begin
      w_cand = {1'b0, r_rr} + (RRW+1)'(k);
      if (w_cand >= (RRW+1)'(N_SRC)) begin
        w_cand = w_cand - (RRW+1)'(N_SRC);
      end
      if (!w_grant_vld && !w_empty[w_cand[RRW-1:0]]) begin
        w_grant_vld = 1'b1;
        w_grant_idx = w_cand[RRW-1:0];
      end
    end
    if (w_grant_vld) begin
      w_grant_vec[w_grant_idx] = 1'b1;
    end
  end

  assign w_head_sel = w_head[w_grant_idx];
  assign w_rr_next  = (w_grant_idx == RRW'(N_SRC - 1)) ? '0 : w_grant_idx + 1'b1;

  // An incoming result is lost only when its FIFO is full and not draining.
  assign w_drop = src_flag & w_full & ~w_grant_vec;

  always_comb begin
    w_stall_next = 1'b0;
    w_busy       = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      if (w_count_next[k] >= CW'(STALL_TH)) begin
        w_stall_next = 1'b1;
      end
      if (w_count[k] != '0) begin
        w_busy = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr       <= '0;
      r_wr_flag  <= 1'b0;
      r_wr_entry <= '0;
      r_stall    <= 1'b0;
      r_ovf      <= '0;
    end else begin
      r_wr_flag <= w_grant_vld;
      if (w_grant_vld) begin
        r_wr_entry <= w_head_sel;
        r_rr       <= w_rr_next;
      end
      r_stall <= w_stall_next;
      r_ovf   <= r_ovf | w_drop;
    end
  end

  assign wr_flag      = r_wr_flag;
  assign wr_address   = r_wr_entry.address;
  assign wr_data      = r_wr_entry.data;
  assign stall_req    = r_stall;
  assign busy         = w_busy;
  assign overflow_err = r_ovf;

endmodule

// File: tb/tb_fpu_writeback.sv
module tb_fpu_writeback;

  localparam int N  = 4;
  localparam int DP = 4;
  localparam int TH = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [N-1:0]  src_flag = '0;
  logic [5*N-1:0]  src_address = '0;
  logic [32*N-1:0] src_data = '0;
  logic          wr_flag;
  logic [4:0]    wr_address;
  logic [31:0]   wr_data;
  logic          stall_req;
  logic          busy;
  logic [N-1:0]  overflow_err;

  int tests = 0;
  int fails = 0;

  fpu_writeback #(.N_SRC(N), .DEPTH(DP), .STALL_TH(TH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .src_flag     (src_flag),
    .src_address  (src_address),
    .src_data     (src_data),
    .wr_flag      (wr_flag),
    .wr_address   (wr_address),
    .wr_data      (wr_data),
    .stall_req    (stall_req),
    .busy         (busy),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  // Behavioural model: one queue per source, a round-robin pointer.
  logic [36:0]  m_q [N][$];
  int           m_rr;
  logic         m_wr_flag;
  logic [4:0]   m_wr_addr;
  logic [31:0]  m_wr_data;
  logic         m_stall;
  logic         m_busy;
  logic [N-1:0] m_ovf;
  int           m_src;
  int           m_accepted;

  function automatic int model_grant();
    int g;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && m_q[(m_rr + k) % N].size() > 0) g = (m_rr + k) % N;
    end
    return g;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_q[i].delete();
    m_rr = 0; m_wr_flag = 0; m_wr_addr = '0; m_wr_data = '0;
    m_stall = 0; m_busy = 0; m_ovf = '0; m_src = -1; m_accepted = 0;
  endtask

  task automatic model_edge(input logic [N-1:0] f, input logic [5*N-1:0] a,
                            input logic [32*N-1:0] d);
    int g;
    logic [36:0] e;
    g = model_grant();
    if (g >= 0) begin
      e = m_q[g].pop_front();
      m_wr_flag = 1; m_wr_addr = e[36:32]; m_wr_data = e[31:0];
      m_rr = (g + 1) % N; m_src = g;
    end else begin
      m_wr_flag = 0; m_src = -1;
    end
    for (int i = 0; i < N; i++) begin
      if (f[i]) begin
        if (m_q[i].size() < DP) begin
          m_q[i].push_back({a[5*i +: 5], d[32*i +: 32]});
          m_accepted++;
        end else begin
          m_ovf[i] = 1'b1;
        end
      end
    end
    m_stall = 0; m_busy = 0;
    for (int i = 0; i < N; i++) begin
      if (m_q[i].size() >= TH) m_stall = 1;
      if (m_q[i].size() > 0) m_busy = 1;
    end
  endtask

  function automatic logic [43:0] act_vec();
    return {wr_flag, wr_address, wr_data, stall_req, busy, overflow_err};
  endfunction

  function automatic logic [43:0] exp_vec();
    return {m_wr_flag, m_wr_addr, m_wr_data, m_stall, m_busy, m_ovf};
  endfunction

  // Drive one cycle of inputs, advance one edge, settle at the falling edge.
  task automatic step(input logic [N-1:0] f, input logic [5*N-1:0] a,
                      input logic [32*N-1:0] d);
    src_flag = f; src_address = a; src_data = d;
    @(posedge clk);
    model_edge(f, a, d);
    @(negedge clk);
    src_flag = '0;
    if (wr_flag)
      $display("[TB] write addr=%0d data=%h (model src %0d)", wr_address, wr_data, m_src);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rstn = 1;
  endtask

  function automatic logic [32*N-1:0] rand_data();
    logic [32*N-1:0] v;
    for (int i = 0; i < N; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [5*N-1:0] rand_addr();
    logic [5*N-1:0] v;
    for (int i = 0; i < N; i++) v[5*i +: 5] = 5'($urandom_range(0, 31));
    return v;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rstn = 0;
    #1;
    tests++;
    if (act_vec() !== 44'd0) begin
      fails++; $display("FAIL reset_state got=%h want=0", act_vec());
    end
    do_reset();
    tests++;
    if (act_vec() !== exp_vec()) begin
      fails++; $display("FAIL reset_release got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_single_push();
    logic [5*N-1:0] a;
    logic [32*N-1:0] d;
    do_reset();
    a = '0; d = '0;
    a[4:0] = 5'd3; d[31:0] = 32'h3F800000;
    step(4'b0001, a, d);
    tests++;
    if (wr_flag !== 1'b0 || busy !== 1'b1) begin
      fails++; $display("FAIL single_t wr_flag=%b busy=%b want 0/1", wr_flag, busy);
    end
    step('0, '0, '0);
    tests++;
    if (wr_flag !== 1'b1 || wr_address !== 5'd3 || wr_data !== 32'h3F800000 || busy !== 1'b0) begin
      fails++; $display("FAIL single_t1 got %b/%0d/%h busy=%b want 1/3/3f800000 busy=0",
                        wr_flag, wr_address, wr_data, busy);
    end
    step('0, '0, '0);
    tests++;
    if (wr_flag !== 1'b0 || act_vec() !== exp_vec()) begin
      fails++; $display("FAIL single_t2 got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_all_sources();
    logic [5*N-1:0] a;
    logic [32*N-1:0] d;
    do_reset();
    for (int i = 0; i < N; i++) a[5*i +: 5] = 5'(i + 1);
    d = rand_data();
    step(4'b1111, a, d);
    for (int k = 0; k < N; k++) begin
      step('0, '0, '0);
      tests++;
      if (wr_flag !== 1'b1 || wr_address !== 5'(k + 1) || act_vec() !== exp_vec()) begin
        fails++; $display("FAIL all_src_%0d got flag=%b addr=%0d want 1/%0d", k, wr_flag, wr_address, k + 1);
      end
    end
    // rr must be back at 0: contested sources 3 and 0 resolve to source 0.
    a = '0; a[4:0] = 5'd10; a[19:15] = 5'd13;
    step(4'b1001, a, d);
    step('0, '0, '0);
    tests++;
    if (wr_flag !== 1'b1 || wr_address !== 5'd10) begin
      fails++; $display("FAIL all_src_rr got flag=%b addr=%0d want 1/10", wr_flag, wr_address);
    end
    step('0, '0, '0);
    tests++;
    if (wr_address !== 5'd13 || act_vec() !== exp_vec()) begin
      fails++; $display("FAIL all_src_rr2 got=%h want=%h", act_vec(), exp_vec());
    end
  endtask

  task automatic test_fairness();
    logic [5*N-1:0] a;
    logic [32*N-1:0] d;
    int src2_step;
    int next0;
    int bad;
    do_reset();
    src2_step = -1; next0 = 0; bad = 0;
    for (int c = 0; c < 12; c++) begin
      a = '0; d = '0;
      a[4:0] = 5'(c + 1); d[31:0] = 32'(c);
      a[14:10] = 5'd20; d[95:64] = 32'hAAAA;
      step((c < 10 ? 4'b0001 : 4'b0000) | (c == 2 ? 4'b0100 : 4'b0000), a, d);
      if (wr_flag && wr_address == 5'd20 && src2_step < 0) src2_step = c;
      else if (wr_flag) begin
        if (wr_data !== 32'(next0)) bad++;
        next0++;
      end
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL fair_cyc%0d got=%h want=%h", c, act_vec(), exp_vec());
      end
    end
    tests++;
    if (src2_step < 3 || src2_step > 4) begin
      fails++; $display("FAIL fair_src2 written at step %0d want 3..4", src2_step);
    end
    tests++;
    if (bad != 0 || next0 != 10) begin
      fails++; $display("FAIL fair_order misordered=%0d writes=%0d want 0/10", bad, next0);
    end
  endtask

  task automatic test_stall_overflow();
    int writes;
    int first_stall;
    do_reset();
    writes = 0; first_stall = -1;
    for (int c = 0; c < 8; c++) begin
      step(4'b1111, rand_addr(), rand_data());
      if (wr_flag) writes++;
      if (stall_req && first_stall < 0) first_stall = c;
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL stall_cyc%0d got=%h want=%h", c, act_vec(), exp_vec());
      end
    end
    for (int c = 0; c < 30 && busy; c++) begin
      step('0, '0, '0);
      if (wr_flag) writes++;
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL stall_drain%0d got=%h want=%h", c, act_vec(), exp_vec());
      end
    end
    step('0, '0, '0);
    tests++;
    if (first_stall != 1) begin
      fails++; $display("FAIL stall_rise at step %0d want 1", first_stall);
    end
    tests++;
    if (overflow_err !== 4'hF || busy !== 1'b0 || stall_req !== 1'b0) begin
      fails++; $display("FAIL ovf_sticky ovf=%h busy=%b stall=%b want f/0/0", overflow_err, busy, stall_req);
    end
    tests++;
    if (writes != m_accepted) begin
      fails++; $display("FAIL ovf_count writes=%0d want %0d", writes, m_accepted);
    end
  endtask

  task automatic test_full_push_pop();
    int events;
    int g;
    int sz;
    logic [N-1:0] f;
    do_reset();
    events = 0;
    for (int c = 0; c < 20; c++) begin
      g = model_grant();
      sz = m_q[0].size();
      f = 4'b1110;
      if (sz < DP || g == 0) f[0] = 1'b1;
      step(f, rand_addr(), rand_data());
      if (sz == DP && g == 0) begin
        events++;
        tests++;
        if (dut.g_src[0].u_fifo.r_count !== 3'd4 || overflow_err[0] !== 1'b0) begin
          fails++; $display("FAIL full_pushpop count=%0d ovf0=%b want 4/0",
                            dut.g_src[0].u_fifo.r_count, overflow_err[0]);
        end
      end
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++; $display("FAIL full_cyc%0d got=%h want=%h", c, act_vec(), exp_vec());
      end
    end
    tests++;
    if (events == 0) begin
      fails++; $display("FAIL full_pushpop scenario never reached");
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    step(4'b0111, rand_addr(), rand_data());
    step(4'b0001, rand_addr(), rand_data());
    tests++;
    if (wr_flag !== 1'b1 || busy !== 1'b1 || act_vec() !== exp_vec()) begin
      fails++; $display("FAIL mid_pre got=%h want=%h", act_vec(), exp_vec());
    end
    #2 rstn = 0;
    #1;
    tests++;
    if (wr_flag !== 1'b0 || stall_req !== 1'b0 || busy !== 1'b0 || act_vec() !== 44'd0) begin
      fails++; $display("FAIL mid_reset got=%h want=0", act_vec());
    end
    model_clear();
    @(negedge clk);
    rstn = 1;
    for (int c = 0; c < 5; c++) begin
      step('0, '0, '0);
      tests++;
      if (wr_flag !== 1'b0 || act_vec() !== exp_vec()) begin
        fails++; $display("FAIL mid_stale%0d got=%h want=%h", c, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] f;
    int errs;
    do_reset();
    errs = 0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) f[i] = ($urandom_range(0, 9) < 3);
      step(f, rand_addr(), rand_data());
      tests++;
      if (act_vec() !== exp_vec()) begin
        fails++; errs++;
        if (errs < 10) $display("FAIL rand_cyc%0d got=%h want=%h", c, act_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_single_push();
    test_all_sources();
    test_fairness();
    test_stall_overflow();
    test_full_push_pop();
    test_reset_mid_burst();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fpu_writeback.md
# fpu_writeback

Writeback collector placed directly downstream of the pipelined FPU units (fadd, fsub, fmul, ...). It gathers each unit's tagged result (`flag`, `address`, `result`), buffers it per source, and serialises all results onto the single float-register-file write port using round-robin arbitration. It also raises a throttle request to the issue stage before any per-source buffer can overflow, because the FPU pipelines are fixed-latency and cannot stall.

## Interface
Parameters:
- `N_SRC`, 4: number of FPU result sources.
- `DEPTH`, 4: per-source FIFO depth, power of two, at least 2.
- `STALL_TH`, 2: occupancy at which `stall_req` asserts. Must be at most `DEPTH`.

Ports:
- `clk`  in  1: single clock. All state changes on the rising edge.
- `rstn`  in  1: asynchronous, active-low reset.
- `src_flag`  in  N_SRC: per-source result valid. This is the unit's `flag_out`.
- `src_address`  in  5*N_SRC: destination register per source. Source i is at `[5i+4:5i]`.
- `src_data`  in  32*N_SRC: result word per source. Source i is at `[32i+31:32i]`.
- `wr_flag`  out  1: register-file write enable. Registered.
- `wr_address`  out  5: register-file write index. Registered.
- `wr_data`  out  32: register-file write data. Registered.
- `stall_req`  out  1: throttle request to the issue stage. Registered.
- `busy`  out  1: at least one FIFO is non-empty. Combinational from counts.
- `overflow_err`  out  N_SRC: sticky per-source overflow indication.

## Operation
- Each source has a FIFO of `DEPTH` entries. An entry is {address[4:0], data[31:0]}.
- **Push:** when `src_flag[i]` is 1 at an edge, `src_address`/`src_data` of source i are written into FIFO i.
- **Arbitration:** each cycle, the grant goes to the first non-empty FIFO searching upward from pointer `rr`, wrapping modulo `N_SRC`.
  - Pop the granted FIFO.
  - Register its head onto `wr_*` with `wr_flag`=1.
  - Set `rr` to grant+1 (mod `N_SRC`).
  - If all FIFOs are empty: `wr_flag`=0, `wr_address`/`wr_data` hold their previous values, `rr` is unchanged.
- **Push and pop on the same FIFO in the same cycle:**
  - Always legal, including when the FIFO is full. Occupancy is unchanged.
  - On an empty FIFO, the pushed entry is not poppable until the next cycle. There is no bypass.
- **Overflow:** a push to a full FIFO that is not popped in the same cycle drops the incoming entry. The FIFO contents are unchanged and `overflow_err[i]` sets; it clears only on reset.
- **Ordering:** results from one source are written in arrival order. There is no ordering guarantee between sources. The issue stage's scoreboard handles WAW hazards.
- **Stall:** `stall_req` is registered and is 1 when any FIFO's post-update count is at least `STALL_TH`.
- **Width rules:**
  - Counts are log2(`DEPTH`)+1 bits.
  - Read/write pointers are log2(`DEPTH`) bits and wrap naturally.
  - `rr` is ceil(log2(`N_SRC`)) bits and is explicitly wrapped to 0 after `N_SRC`-1.

## Timing
- **Reset values:** `wr_flag`=0, `wr_address`=0, `wr_data`=0, `stall_req`=0, `overflow_err`=0, `busy`=0. All FIFOs are empty and `rr`=0.
- **Latency:** a result sampled at edge t into an empty, uncontested FIFO appears on `wr_*` after edge t+1, i.e. 2 cycles from the producer's `flag_out` register.
- **Throughput:** one register write per cycle in total.
- **Worst-case wait:** an entry at the head of its FIFO is written within `N_SRC` cycles.
- **Reset mid-operation:** `rstn` low asynchronously discards all buffered entries and forces the reset values immediately. The first push is accepted at the first edge after `rstn` returns high.

## Structure
- Shared package `fpu_pkg`:
  - `FREG_ADDR_W`=5.
  - `FDATA_W`=32.
  - typedef `fwb_entry_t` = {address, data}.
- Sub-module `fpu_wb_fifo`: a single-source FIFO with `DEPTH` parameter, push/pop/full/empty/count, asynchronous active-low reset. It is instantiated `N_SRC` times via generate.
- The top level contains the round-robin arbiter, the output registers, the stall logic and the overflow logic.

## Test plan
- **Single push:** after reset, `src_flag`=4'b0001, address 3, data 32'h3F800000 at edge t. Required: `wr_flag`=1, `wr_address`=3, `wr_data`=32'h3F800000 after edge t+1. `wr_flag`=0 the following cycle. `busy` falls.
- **All sources at once:** all four sources push in one cycle with addresses 1, 2, 3, 4. Required: writes of 1, 2, 3, 4 on four consecutive cycles. `rr` ends at 0.
- **Round-robin fairness:** source 0 pushes every cycle and source 2 pushes once. Required: the source 2 write appears within 2 cycles of becoming head, and source 0 order is preserved.
- **Stall and overflow:** `DEPTH`=4, `STALL_TH`=2, sources 0–3 all push every cycle for 8 cycles.
  - Required: `stall_req` rises once any FIFO holds 2 entries.
  - Once a FIFO is full with no pop in the same cycle, further pushes to it are dropped and its `overflow_err` bit sets and stays set.
  - The number of writes equals the number of entries accepted.
- **Full FIFO, push and pop together:** with FIFO 0 full and granted, a push in the same cycle is accepted. Required: count stays 4 and `overflow_err[0]` stays 0.
- **Reset mid-burst:** pull `rstn` low with 3 entries buffered. Required: `wr_flag`, `stall_req` and `busy` go to 0 immediately, and no stale write appears after release.
